// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// Module   : cdb_arbiter_pkg
// Brief    : Shared FU-result and CDB packet types for the CDB arbiter slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

  localparam int C_XLEN      = 32;
  localparam int C_ROB_TAG_W = 5;
  localparam int C_NUM_FU    = 4;

  typedef struct packed {
    logic                   done;
    logic [C_XLEN-1:0]      v;
    logic [C_ROB_TAG_W-1:0] rob_tag;
    logic                   take_branch;
  } FU_OUT_PACKET;

  typedef struct packed {
    logic                   valid;
    logic [C_ROB_TAG_W-1:0] rob_tag;
    logic [C_XLEN-1:0]      v;
    logic                   take_branch;
  } CDB_PACKET;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin select, searching upward from ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  int               w_sum;
  logic [PTR_W-1:0] w_idx;

  // First requester at or after ptr, wrapping modulo N, wins.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PTR_W'(w_sum);
      if (!gnt_valid && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_valid  = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin FU-to-CDB arbiter with one-cycle registered broadcast.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = C_NUM_FU,
  parameter int PTR_W  = $clog2(NUM_FU)
) (
  input  logic         clock,
  input  logic         reset,
  input  FU_OUT_PACKET fu_out_packet [NUM_FU],
  input  logic         squash,
  output logic [NUM_FU-1:0] ack,
  output CDB_PACKET    cdb_packet
);

  localparam logic [PTR_W-1:0] C_LAST_FU = PTR_W'(NUM_FU - 1);

  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_gnt;
  logic              w_gnt_valid;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  r_rr_ptr;
  FU_OUT_PACKET      w_sel;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_req
    assign w_req[i] = fu_out_packet[i].done;
  end

  rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .gnt       (w_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_sel = fu_out_packet[w_gnt_idx];

  // Squash drains every finished FU so no stale result survives the flush.
  always_comb begin
    ack = '0;
    if (!reset) ack = squash ? w_req : w_gnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_packet <= '0;
      r_rr_ptr   <= '0;
    end else if (squash) begin
      cdb_packet.valid <= 1'b0;
      r_rr_ptr         <= '0;
    end else if (w_gnt_valid) begin
      cdb_packet.valid       <= 1'b1;
      cdb_packet.rob_tag     <= w_sel.rob_tag;
      cdb_packet.v           <= w_sel.v;
      cdb_packet.take_branch <= w_sel.take_branch;
      r_rr_ptr               <= (w_gnt_idx == C_LAST_FU) ? '0 : w_gnt_idx + 1'b1;
    end else begin
      cdb_packet.valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU = 4;

  logic         clock;
  logic         reset;
  logic         squash;
  FU_OUT_PACKET fu_out_packet [NUM_FU];
  logic [NUM_FU-1:0] ack;
  CDB_PACKET    cdb_packet;

  int n_tests;
  int n_fail;

  logic [C_XLEN-1:0]      fu_v   [NUM_FU];
  logic [C_ROB_TAG_W-1:0] fu_tag [NUM_FU];
  logic                   fu_tb  [NUM_FU];

  cdb_arbiter #(.NUM_FU(NUM_FU)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_out_packet (fu_out_packet),
    .squash        (squash),
    .ack           (ack),
    .cdb_packet    (cdb_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, check the combinational ack, then cross the edge.
  task automatic cycle(input string tag, input logic [3:0] done_mask, input logic sq,
                       input logic rst, input logic [3:0] exp_ack);
    @(negedge clock);
    for (int i = 0; i < NUM_FU; i++) begin
      fu_out_packet[i].done        = done_mask[i];
      fu_out_packet[i].v           = fu_v[i];
      fu_out_packet[i].rob_tag     = fu_tag[i];
      fu_out_packet[i].take_branch = fu_tb[i];
    end
    squash = sq;
    reset  = rst;
    #1;
    check({tag, ".ack"}, 64'(ack), 64'(exp_ack));
    @(posedge clock);
    #1;
  endtask

  task automatic check_cdb(input string tag, input logic exp_valid, input int fu,
                           input logic [1:0] exp_ptr);
    check({tag, ".valid"}, 64'(cdb_packet.valid), 64'(exp_valid));
    if (exp_valid) begin
      check({tag, ".rob_tag"}, 64'(cdb_packet.rob_tag), 64'(fu_tag[fu]));
      check({tag, ".v"}, 64'(cdb_packet.v), 64'(fu_v[fu]));
      check({tag, ".take_branch"}, 64'(cdb_packet.take_branch), 64'(fu_tb[fu]));
    end
    check({tag, ".rr_ptr"}, 64'(dut.r_rr_ptr), 64'(exp_ptr));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fu_v[0] = 32'hAAAA_0000; fu_tag[0] = 5'd3;  fu_tb[0] = 1'b0;
    fu_v[1] = 32'h1111_0001; fu_tag[1] = 5'd8;  fu_tb[1] = 1'b1;
    fu_v[2] = 32'h0000_1234; fu_tag[2] = 5'd5;  fu_tb[2] = 1'b0;
    fu_v[3] = 32'hDEAD_0003; fu_tag[3] = 5'd11; fu_tb[3] = 1'b1;
    squash = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < NUM_FU; i++) fu_out_packet[i] = '0;

    // Reset then idle.
    cycle("rst0", 4'b0000, 1'b0, 1'b1, 4'b0000);
    cycle("rst1", 4'b0000, 1'b0, 1'b1, 4'b0000);
    check_cdb("rst", 1'b0, 0, 2'd0);
    cycle("idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    check_cdb("idle", 1'b0, 0, 2'd0);

    // Single request from FU2.
    cycle("single", 4'b0100, 1'b0, 1'b0, 4'b0100);
    check_cdb("single", 1'b1, 2, 2'd3);

    // FU0 and FU3 contend with rr_ptr = 3: FU3 first, then wrap to FU0.
    cycle("wrap_a", 4'b1001, 1'b0, 1'b0, 4'b1000);
    check_cdb("wrap_a", 1'b1, 3, 2'd0);
    cycle("wrap_b", 4'b0001, 1'b0, 1'b0, 4'b0001);
    check_cdb("wrap_b", 1'b1, 0, 2'd1);

    // Squash with nothing pending just returns the pointer to 0.
    cycle("sq_idle", 4'b0000, 1'b1, 1'b0, 4'b0000);
    check_cdb("sq_idle", 1'b0, 0, 2'd0);

    // All FUs requesting every cycle: strict rotation, no bubbles.
    cycle("all0", 4'b1111, 1'b0, 1'b0, 4'b0001);
    check_cdb("all0", 1'b1, 0, 2'd1);
    cycle("all1", 4'b1111, 1'b0, 1'b0, 4'b0010);
    check_cdb("all1", 1'b1, 1, 2'd2);
    cycle("all2", 4'b1111, 1'b0, 1'b0, 4'b0100);
    check_cdb("all2", 1'b1, 2, 2'd3);
    cycle("all3", 4'b1111, 1'b0, 1'b0, 4'b1000);
    check_cdb("all3", 1'b1, 3, 2'd0);
    cycle("all4", 4'b1111, 1'b0, 1'b0, 4'b0001);
    check_cdb("all4", 1'b1, 0, 2'd1);

    // Squash drains FU1 and FU2 without broadcasting either.
    cycle("squash", 4'b0110, 1'b1, 1'b0, 4'b0110);
    check_cdb("squash", 1'b0, 0, 2'd0);
    cycle("post_sq", 4'b0000, 1'b0, 1'b0, 4'b0000);
    check_cdb("post_sq", 1'b0, 0, 2'd0);

    // Reset arrives while a broadcast is on the bus and FU1 is pending.
    cycle("pre_rst", 4'b0001, 1'b0, 1'b0, 4'b0001);
    check_cdb("pre_rst", 1'b1, 0, 2'd1);
    cycle("mid_rst", 4'b0010, 1'b0, 1'b1, 4'b0000);
    check_cdb("mid_rst", 1'b0, 0, 2'd0);
    cycle("after_rst", 4'b0010, 1'b0, 1'b0, 4'b0010);
    check_cdb("after_rst", 1'b1, 1, 2'd2);
    cycle("final_idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    check_cdb("final_idle", 1'b0, 0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
